// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for the largest supported timeout (1023).
    localparam int CNT_W = $clog2(1024);

    // funct3[1:0] of 10 and 11 are both treated as a word access.
    function automatic logic [1:0] size_of(input logic [1:0] f3_lo);
        return f3_lo[1] ? SZ_WORD : f3_lo;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Data bus between the MEM-stage controller (master) and data memory (slave).
interface dmem_ctrl_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/dmem_align.sv
// Byte-lane handling: store strobes/replication, misalign detection and
// load lane extraction with sign/zero extension. Purely combinational.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_off_i,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_data_i,
    input  logic        st_write_i,
    output logic        misalign_o,
    output logic [3:0]  st_wstrb_o,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_off_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [1:0] st_sz;
    logic [1:0] ld_sz;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    // Store side: strobes only for writes, data replicated across lanes.
    always_comb begin
        st_sz      = size_of(st_size_i);
        misalign_o = ((st_sz == SZ_HALF) && st_off_i[0]) ||
                     ((st_sz == SZ_WORD) && (st_off_i != 2'b00));
        case (st_sz)
            SZ_BYTE: begin
                st_wstrb_o = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                st_wstrb_o = 4'b0011 << {st_off_i[1], 1'b0};
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_wstrb_o = 4'b1111;
                st_wdata_o = st_data_i;
            end
        endcase
        if (!st_write_i) begin
            st_wstrb_o = 4'b0000;
        end
    end

    // Load side: pick the addressed lane, then extend per funct3[2].
    always_comb begin
        ld_sz = size_of(ld_funct3_i[1:0]);
        case (ld_off_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_sz)
            SZ_BYTE: ld_data_o = ld_funct3_i[2] ? {24'd0, ld_byte}
                                                : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = ld_funct3_i[2] ? {16'd0, ld_half}
                                                : {{16{ld_half[15]}}, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: one word-aligned bus transaction per
// load/store, stalling the pipeline until it completes, times out or is
// rejected as misaligned.
//
//  state | meaning
//  IDLE  | waiting for a load/store in MEM; aligned -> REQ, misaligned -> DONE
//  REQ   | dbus_req high with fields stable until gnt
//  WAIT  | granted, waiting for rvalid
//  DONE  | result/error valid, stall released for this one cycle
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_mem_read_i,
    input  logic              mem_mem_write_i,
    input  logic [31:0]       mem_alu_out_i,
    input  logic [31:0]       mem_rs2_data_i,
    input  logic [2:0]        mem_funct3_i,
    dmem_ctrl_if.master       dbus,
    output logic              mem_stall_o,
    output logic [31:0]       load_data_o,
    output logic              err_misalign_o,
    output logic              err_bus_o
);

    dmem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             req_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      wdata_q;
    logic [1:0]       ld_off_q;
    logic [2:0]       ld_funct3_q;
    logic [31:0]      load_q;
    logic             emis_q;
    logic             ebus_q;

    logic             access;
    logic             misalign;
    logic [3:0]       st_wstrb;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_fmt;
    logic             timeout_hit;

    assign access = mem_mem_read_i | mem_mem_write_i;

    dmem_align u_align (
        .st_off_i    (mem_alu_out_i[1:0]),
        .st_size_i   (mem_funct3_i[1:0]),
        .st_data_i   (mem_rs2_data_i),
        .st_write_i  (mem_mem_write_i),
        .misalign_o  (misalign),
        .st_wstrb_o  (st_wstrb),
        .st_wdata_o  (st_wdata),
        .ld_off_i    (ld_off_q),
        .ld_funct3_i (ld_funct3_q),
        .ld_rdata_i  (dbus.dbus_rdata),
        .ld_data_o   (ld_fmt)
    );

    // Cycle count of the current REQ/WAIT residency, including this cycle.
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        timeout_hit = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end

    // Transaction FSM with registered bus fields, result and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            ld_off_q    <= '0;
            ld_funct3_q <= '0;
            load_q      <= '0;
            emis_q      <= 1'b0;
            ebus_q      <= 1'b0;
        end else begin
            // Error flags are set only on entry to DONE, so they last one cycle.
            emis_q <= 1'b0;
            ebus_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (misalign) begin
                            load_q  <= '0;
                            emis_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            req_q       <= 1'b1;
                            we_q        <= mem_mem_write_i;
                            addr_q      <= {mem_alu_out_i[31:2], 2'b00};
                            wstrb_q     <= st_wstrb;
                            wdata_q     <= st_wdata;
                            ld_off_q    <= mem_alu_out_i[1:0];
                            ld_funct3_q <= mem_funct3_i;
                            cnt_q       <= '0;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    // A completing response wins over a coincident timeout.
                    if (dbus.dbus_gnt && dbus.dbus_rvalid) begin
                        req_q   <= 1'b0;
                        load_q  <= we_q ? 32'd0 : ld_fmt;
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        load_q  <= '0;
                        ebus_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (dbus.dbus_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (dbus.dbus_rvalid) begin
                        load_q  <= we_q ? 32'd0 : ld_fmt;
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        load_q  <= '0;
                        ebus_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The pipeline advances only at the end of the DONE cycle.
    always_comb begin
        mem_stall_o = access && (state_q != DONE) && !rst;
    end

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_wstrb = wstrb_q;
    assign dbus.dbus_wdata = wdata_q;
    assign load_data_o     = load_q;
    assign err_misalign_o  = emis_q;
    assign err_bus_o       = ebus_q;

endmodule
